// File: rtl/sweep_scan_ctrl_pkg.sv
// Shared types, constants and helpers for the 4-digit sweep/scan controller.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int         NDIG    = 4;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  // Width of the shared dwell/gap counter: must hold 8*STEP-1 and BLANK-1,
  // and the on-time limit compare uses one extra bit on top of this.
  function automatic int cnt_width(input int step, input int blank);
    int top;
    top = (8 * step > blank) ? 8 * step : blank;
    return $clog2(top + 1);
  endfunction

  // Hex digit idx of a 16-bit display value; digit 0 is the rightmost nibble.
  function automatic logic [3:0] nib_sel(input logic [15:0] value, input logic [1:0] idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

  // Leading-zero test: digit idx (1..3) is suppressed when it and every
  // digit to its left are zero. Digit 0 is always shown.
  function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] idx);
    logic z;
    z = 1'b1;
    for (int k = 1; k < NDIG; k++) begin
      if (k >= int'(idx)) z = z & (value[4*k +: 4] == 4'h0);
    end
    return (idx != 2'd0) && z;
  endfunction

endpackage

// File: rtl/sweep_scan_ctrl_if.sv
// Control/update/display signal bundle between a host and the scan controller.
interface sweep_scan_ctrl_if;
  logic        en;
  logic [2:0]  bright;
  logic        lzs;
  logic        upd;
  logic [15:0] upd_data;
  logic        upd_ack;
  logic [3:0]  nibble;
  logic        blank;
  logic [3:0]  dig_n;
  logic        frame_start;

  // Host side: drives controls and updates, observes display outputs.
  modport master (
    output en, bright, lzs, upd, upd_data,
    input  upd_ack, nibble, blank, dig_n, frame_start
  );

  // Controller side.
  modport slave (
    input  en, bright, lzs, upd, upd_data,
    output upd_ack, nibble, blank, dig_n, frame_start
  );
endinterface

// File: rtl/sweep_scan_ctrl_scan_timer.sv
// Shared dwell/gap counter. The FSM clears it on every phase change; it
// exposes the next count so the controller can register look-ahead outputs.
module scan_timer
  import sweep_pkg::*;
#(
  parameter int STEP  = 256,
  parameter int BLANK = 16,
  parameter int CW    = cnt_width(STEP, BLANK)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          clr,
  output logic [CW-1:0] cnt_nxt,
  output logic          dwell_tc,
  output logic          gap_tc
);

  localparam logic [CW-1:0] DWELL_LAST = CW'(8 * STEP - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((BLANK > 0) ? BLANK - 1 : 0);

  logic [CW-1:0] cnt;

  assign cnt_nxt  = clr ? '0 : cnt + 1'b1;
  assign dwell_tc = (cnt == DWELL_LAST);
  assign gap_tc   = (BLANK > 0) && (cnt == GAP_LAST);

  // Counter register.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values, independent of statement order.
    if (!RST_N) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/sweep_scan_ctrl.sv
// Sequencing controller for a 4-digit multiplexed 7-segment display:
// digit scan with blanking gap, PWM brightness, leading-zero suppression
// and frame-aligned double buffering of the 16-bit display value.
// Outputs are registered from the next-state values, so they line up with
// the state the controller is in during the same cycle.
module sweep_scan_ctrl
  import sweep_pkg::*;
#(
  parameter int STEP  = 256,
  parameter int BLANK = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  sweep_scan_ctrl_if.slave bus
);

  localparam int CW = cnt_width(STEP, BLANK);

  state_t        state, state_d;
  logic [1:0]    idx, idx_d;
  logic [15:0]   active, active_d;
  logic [15:0]   shadow, shadow_d;
  logic          pending, pending_d;
  logic          boundary;
  logic          clr;
  logic [CW-1:0] cnt_d;
  logic          dwell_tc, gap_tc;

  logic [CW:0]   on_lim;
  logic          is_on;
  logic [3:0]    dig_n_d;
  logic [3:0]    nibble_d;
  logic          blank_d;
  logic          ack_d;

  scan_timer #(.STEP(STEP), .BLANK(BLANK), .CW(CW)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr      (clr),
    .cnt_nxt  (cnt_d),
    .dwell_tc (dwell_tc),
    .gap_tc   (gap_tc)
  );

  // State register plus display buffers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the value buffers are reset as well, so power-up shows 0 and a
      // value pending at reset is deliberately dropped.
      state   <= IDLE;
      idx     <= 2'd0;
      active  <= 16'h0000;
      shadow  <= 16'h0000;
      pending <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      active  <= active_d;
      shadow  <= shadow_d;
      pending <= pending_d;
    end
  end

  // Next state, digit index, counter restart and double-buffer update.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state;
    idx_d     = idx;
    clr       = 1'b0;
    boundary  = 1'b0;
    active_d  = active;
    shadow_d  = shadow;
    pending_d = pending;

    case (state)
      IDLE: begin
        clr   = 1'b1;
        idx_d = 2'd0;
        if (bus.en) begin
          state_d  = ON;
          boundary = 1'b1;
        end
      end
      ON: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          clr     = 1'b1;
        end else if (dwell_tc) begin
          clr = 1'b1;
          if (BLANK == 0) begin
            idx_d    = idx + 2'd1;
            boundary = (idx == 2'd3);
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!bus.en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          clr     = 1'b1;
        end else if (gap_tc) begin
          clr      = 1'b1;
          state_d  = ON;
          idx_d    = idx + 2'd1;
          boundary = (idx == 2'd3);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        clr     = 1'b1;
      end
    endcase

    // A coincident request wins over an older pending value (last value wins).
    if (boundary && bus.upd) begin
      active_d  = bus.upd_data;
      pending_d = 1'b0;
    end else if (boundary && pending) begin
      active_d  = shadow;
      pending_d = 1'b0;
    end else if (bus.upd) begin
      shadow_d  = bus.upd_data;
      pending_d = 1'b1;
    end
  end

  // Display outputs derived from the state being entered.
  always_comb begin
    on_lim   = ((CW + 1)'(bus.bright) + 1'b1) * (CW + 1)'(STEP);
    is_on    = (state_d == ON) && ({1'b0, cnt_d} < on_lim);
    dig_n_d  = is_on ? ~(4'b0001 << idx_d) : DIG_OFF;
    nibble_d = (state_d == ON) ? nib_sel(active_d, idx_d) : 4'h0;
    blank_d  = !is_on || (bus.lzs && lead_zero(active_d, idx_d));
    ack_d    = boundary && (bus.upd || pending);
  end

  // Output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.dig_n       <= DIG_OFF;
      bus.blank       <= 1'b1;
      bus.nibble      <= 4'h0;
      bus.upd_ack     <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.dig_n       <= dig_n_d;
      bus.blank       <= blank_d;
      bus.nibble      <= nibble_d;
      bus.upd_ack     <= ack_d;
      bus.frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_sweep_scan_ctrl.sv
// Directed bench for sweep_scan_ctrl with STEP=2, BLANK=1 (dwell 16, frame 68).
// Frame layout: digit d is lit in cycles 17d..17d+15, gap at 17d+16.
module tb_sweep_scan_ctrl;

  localparam int FRAME = 68;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [3:0] r_dig [FRAME];
  logic [3:0] r_nib [FRAME];
  logic       r_blk [FRAME];
  logic       r_ack [FRAME];
  logic       r_fs  [FRAME];

  sweep_scan_ctrl_if ifc ();

  sweep_scan_ctrl #(.STEP(2), .BLANK(1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Advance (on falling edges) to a cycle showing frame_start, bounded.
  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    while (ifc.frame_start !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " frame_start"}, 32'(ifc.frame_start), 32'd1);
  endtask

  // Capture one frame starting at the current cycle; optional upd pulses
  // are driven at frame cycles u1/u2.
  task automatic record_frame(input int u1, input logic [15:0] d1,
                              input int u2, input logic [15:0] d2);
    for (int c = 0; c < FRAME; c++) begin
      r_dig[c] = ifc.dig_n;
      r_nib[c] = ifc.nibble;
      r_blk[c] = ifc.blank;
      r_ack[c] = ifc.upd_ack;
      r_fs[c]  = ifc.frame_start;
      ifc.upd      = (c == u1) || (c == u2);
      ifc.upd_data = (c == u2) ? d2 : d1;
      @(negedge clk);
    end
    ifc.upd = 1'b0;
  endtask

  // Check a captured frame against the value shown, lit cycles per digit
  // and which digits are suppressed, plus acks and frame period.
  task automatic check_frame(input string name, input logic [15:0] val,
                             input int on_cycles, input logic [3:0] supp,
                             input int acks);
    int n_on, n_blk, n_gap, n_fs, n_ack;
    logic [3:0] oh;
    n_gap = 0;
    n_fs  = 0;
    n_ack = 0;
    for (int d = 0; d < 4; d++) begin
      oh    = ~(4'b0001 << d);
      n_on  = 0;
      n_blk = 0;
      for (int c = 17 * d; c < 17 * d + 16; c++) begin
        if (r_dig[c] == oh) n_on++;
        if (r_blk[c]) n_blk++;
      end
      if (r_dig[17 * d + 16] == 4'b1111 && r_blk[17 * d + 16]) n_gap++;
      check($sformatf("%s d%0d on", name, d), 32'(n_on), 32'(on_cycles));
      check($sformatf("%s d%0d first", name, d), 32'(r_dig[17 * d]), 32'(oh));
      check($sformatf("%s d%0d nibble", name, d), 32'(r_nib[17 * d]), 32'(val[4*d +: 4]));
      check($sformatf("%s d%0d blank", name, d), 32'(n_blk),
            supp[d] ? 32'd16 : 32'(16 - on_cycles));
    end
    for (int c = 0; c < FRAME; c++) begin
      if (r_fs[c])  n_fs++;
      if (r_ack[c]) n_ack++;
    end
    check({name, " gaps"}, 32'(n_gap), 32'd4);
    check({name, " fs count"}, 32'(n_fs), 32'd1);
    check({name, " ack count"}, 32'(n_ack), 32'(acks));
    check({name, " ack c0"}, 32'(r_ack[0]), (acks > 0) ? 32'd1 : 32'd0);
    check({name, " period"}, 32'(ifc.frame_start), 32'd1);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    ifc.en       = 1'b0;
    ifc.bright   = 3'd7;
    ifc.lzs      = 1'b0;
    ifc.upd      = 1'b0;
    ifc.upd_data = 16'h0000;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst dig_n", 32'(ifc.dig_n), 32'hF);
    check("rst blank", 32'(ifc.blank), 32'd1);
    check("rst nibble", 32'(ifc.nibble), 32'd0);
    check("rst upd_ack", 32'(ifc.upd_ack), 32'd0);
    check("rst frame_start", 32'(ifc.frame_start), 32'd0);

    // Load 0x4321 while idle; it applies on the first frame after enable.
    rst_n = 1'b1;
    @(negedge clk);
    check("idle dig_n", 32'(ifc.dig_n), 32'hF);
    ifc.upd      = 1'b1;
    ifc.upd_data = 16'h4321;
    @(negedge clk);
    ifc.upd = 1'b0;
    ifc.en  = 1'b1;
    @(negedge clk);
    wait_frame("f1");
    record_frame(-1, 16'h0, -1, 16'h0);
    check_frame("full", 16'h4321, 16, 4'b0000, 1);

    // Minimum brightness: 2 lit cycles per digit, at the start of the dwell.
    ifc.bright = 3'd0;
    record_frame(-1, 16'h0, -1, 16'h0);
    record_frame(-1, 16'h0, -1, 16'h0);
    check_frame("dim", 16'h4321, 2, 4'b0000, 0);
    check("dim c1 on", 32'(r_dig[1]), 32'hE);
    check("dim c2 off", 32'(r_dig[2]), 32'hF);

    // Two updates within one frame: only the last one is applied and acked.
    ifc.bright = 3'd7;
    record_frame(-1, 16'h0, -1, 16'h0);
    record_frame(39, 16'hBEEF, 60, 16'h00A5);
    check_frame("pre", 16'h4321, 16, 4'b0000, 0);
    check("pre d3 kept", 32'(r_nib[51]), 32'h4);

    // Update on the boundary cycle bypasses the shadow into this frame.
    record_frame(67, 16'h9876, -1, 16'h0);
    check_frame("last", 16'h00A5, 16, 4'b0000, 1);
    ifc.lzs = 1'b1;
    record_frame(67, 16'h0070, -1, 16'h0);
    check_frame("bypass", 16'h9876, 16, 4'b0000, 1);

    // Leading-zero suppression; dig_n keeps sweeping for blanked digits.
    record_frame(67, 16'h0000, -1, 16'h0);
    check_frame("lzs70", 16'h0070, 16, 4'b1100, 1);
    record_frame(-1, 16'h0, -1, 16'h0);
    check_frame("lzs00", 16'h0000, 16, 4'b1110, 1);
    ifc.lzs = 1'b0;

    // Disable during the gap after digit 1.
    repeat (33) @(negedge clk);
    check("gap1 dig_n", 32'(ifc.dig_n), 32'hF);
    ifc.en = 1'b0;
    @(negedge clk);
    check("dis dig_n", 32'(ifc.dig_n), 32'hF);
    check("dis blank", 32'(ifc.blank), 32'd1);
    ifc.upd      = 1'b1;
    ifc.upd_data = 16'h1234;
    @(negedge clk);
    ifc.upd = 1'b0;
    repeat (3) @(negedge clk);
    check("idle hold dig_n", 32'(ifc.dig_n), 32'hF);
    check("idle hold fs", 32'(ifc.frame_start), 32'd0);
    check("idle hold ack", 32'(ifc.upd_ack), 32'd0);
    ifc.en = 1'b1;
    @(negedge clk);
    check("reen fs", 32'(ifc.frame_start), 32'd1);
    check("reen dig_n", 32'(ifc.dig_n), 32'hE);
    check("reen ack", 32'(ifc.upd_ack), 32'd1);
    check("reen nibble", 32'(ifc.nibble), 32'h4);

    // Reset mid-ON with a value pending: outputs off at once, pending lost.
    @(negedge clk);
    ifc.upd      = 1'b1;
    ifc.upd_data = 16'h5555;
    @(negedge clk);
    ifc.upd = 1'b0;
    @(negedge clk);
    check("mid on dig_n", 32'(ifc.dig_n), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("async rst dig_n", 32'(ifc.dig_n), 32'hF);
    check("async rst blank", 32'(ifc.blank), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst fs", 32'(ifc.frame_start), 32'd1);
    check("post rst ack", 32'(ifc.upd_ack), 32'd0);
    check("post rst nibble", 32'(ifc.nibble), 32'h0);
    check("post rst dig_n", 32'(ifc.dig_n), 32'hE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
